// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, signed or unsigned
// Ports: clk, rst (async, active-high); start/dA/dB/signedMode in; busy/done/equal/less/greater out.
// Optional EARLY_EXIT_EN: finish at the first differing digit instead of always after N digits.
module seq_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dA,
  input  logic [WIDTH-1:0] dB,
  input  logic             signedMode,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             less,
  output logic             greater
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, COMPARE} state_e;
  // ord encodes the verdict so far: 00 equal, 01 less, 10 greater
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       ord_q, ord_d, ord_n;
  logic             done_q, done_d, eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [DIGIT-1:0] da, db;
  logic             last, diff, fin;
  logic [WIDTH-1:0] msb;
  assign msb = {1'b1, {(WIDTH-1){1'b0}}};
  always_comb begin
    da = a_q[WIDTH-1 -: DIGIT];
    db = b_q[WIDTH-1 -: DIGIT];
    diff = ord_q == 2'b00 && da != db;
    ord_n = ord_q != 2'b00 ? ord_q : da < db ? 2'b01 : da > db ? 2'b10 : 2'b00;
    last = cnt_q == CW'(N - 1);
`ifdef EARLY_EXIT_EN
    fin = last || diff;
`else
    fin = last;
`endif
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    ord_d = ord_q;
    done_d = 1'b0;
    eq_d = eq_q;
    lt_d = lt_q;
    gt_d = gt_q;
    if (state_q == IDLE) begin
      if (start) begin
        // flipping the sign bit maps two's complement order onto unsigned order
        state_d = COMPARE;
        a_d = signedMode ? dA ^ msb : dA;
        b_d = signedMode ? dB ^ msb : dB;
        cnt_d = '0;
        ord_d = 2'b00;
      end
    end else begin
      a_d = a_q << DIGIT;
      b_d = b_q << DIGIT;
      ord_d = ord_n;
      cnt_d = fin ? '0 : cnt_q + CW'(1);
      if (fin) begin
        state_d = IDLE;
        done_d = 1'b1;
        eq_d = ord_n == 2'b00;
        lt_d = ord_n == 2'b01;
        gt_d = ord_n == 2'b10;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      ord_q <= 2'b00;
      done_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      ord_q <= ord_d;
      done_q <= done_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
      gt_q <= gt_d;
    end
  end
  assign busy = state_q == COMPARE;
  assign done = done_q;
  assign equal = eq_q;
  assign less = lt_q;
  assign greater = gt_q;
endmodule

// File: tb/tb_seq_comparator.sv
// tb_seq_comparator: randomized and directed checks of seq_comparator against an arithmetic model
module tb_seq_comparator;
  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N = WIDTH / DIGIT;
  logic clk, rst, start, signedMode, busy, done, equal, less, greater;
  logic [WIDTH-1:0] dA, dB;
  int n_cmp, n_err;
  int pe, pl, pg;
  seq_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .dA(dA), .dB(dB), .signedMode(signedMode),
    .busy(busy), .done(done), .equal(equal), .less(less), .greater(greater)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic int to_val(input int a, input bit s);
    return (s && a >= 128) ? a - 256 : a;
  endfunction
  function automatic int exp_lat(input int a, input int b, input bit s);
`ifdef EARLY_EXIT_EN
    int ua, ub;
    ua = to_val(a, s) - (s ? -128 : 0);
    ub = to_val(b, s) - (s ? -128 : 0);
    for (int k = 1; k <= N; k++)
      if ((ua / (1 << (DIGIT * (N - k)))) % (1 << DIGIT) != (ub / (1 << (DIGIT * (N - k)))) % (1 << DIGIT))
        return k;
    return N;
`else
    return (a + b + int'(s)) * 0 + N;
`endif
  endfunction
  task automatic run_op(input int a, input int b, input bit s, input bit poke);
    int va, vb, lat, got;
    va = to_val(a, s);
    vb = to_val(b, s);
    lat = exp_lat(a, b, s);
    dA = WIDTH'(a);
    dB = WIDTH'(b);
    signedMode = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_e0", 32'(busy), 1);
    chk("done_e0", 32'(done), 0);
    chk("hold_eq", 32'(equal), 32'(pe));
    chk("hold_lt", 32'(less), 32'(pl));
    chk("hold_gt", 32'(greater), 32'(pg));
    got = 0;
    for (int e = 1; e <= N + 2 && got == 0; e++) begin
      if (poke && e == 2) begin
        start = 1'b1;
        dA = WIDTH'(b);
        dB = WIDTH'(a);
        signedMode = ~s;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      dA = WIDTH'($urandom);
      dB = WIDTH'($urandom);
      signedMode = 1'($urandom);
      if (done) begin
        got = 1;
        chk("latency", 32'(e), 32'(lat));
      end else chk("busy_run", 32'(busy), 1);
    end
    chk("done_seen", 32'(got), 1);
    pe = int'(va == vb);
    pl = int'(va < vb);
    pg = int'(va > vb);
    chk("equal", 32'(equal), 32'(pe));
    chk("less", 32'(less), 32'(pl));
    chk("greater", 32'(greater), 32'(pg));
    chk("busy_end", 32'(busy), 0);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    pe = 0;
    pl = 0;
    pg = 0;
    rst = 1'b1;
    start = 1'b0;
    dA = '0;
    dB = '0;
    signedMode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_eq", 32'(equal), 0);
    chk("rst_lt", 32'(less), 0);
    chk("rst_gt", 32'(greater), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h80, 8'h00, 1'b1, 1'b0);
    run_op(8'h80, 8'h00, 1'b0, 1'b0);
    run_op(8'h5A, 8'h5A, 1'b1, 1'b0);
    run_op(8'h5A, 8'h5A, 1'b0, 1'b0);
    run_op(8'h03, 8'h02, 1'b0, 1'b0);
    run_op(8'h01, 8'h02, 1'b0, 1'b0);
    run_op(8'h5A, 8'h5B, 1'b0, 1'b1);
    run_op(8'h5B, 8'h5A, 1'b1, 1'b1);
    @(negedge clk);
    dA = 8'h77;
    dB = 8'h77;
    signedMode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_eq", 32'(equal), 0);
    chk("abort_lt", 32'(less), 0);
    chk("abort_gt", 32'(greater), 0);
    pe = 0;
    pl = 0;
    pg = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_abort_done", 32'(done), 0);
      chk("post_abort_busy", 32'(busy), 0);
    end
    run_op(8'hC3, 8'h3C, 1'b1, 1'b0);
    for (int a = 0; a < 256; a++) run_op(a, 0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      int a, b;
      a = int'($urandom_range(255));
      b = ($urandom_range(3) == 0) ? a : int'($urandom_range(255));
      if ($urandom_range(1) == 1) @(negedge clk);
      run_op(a, b, 1'($urandom), 1'b0);
    end
    if (n_err == 0) $display("all tests passed");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
